// File: rtl/router_input_unit.sv
// router_input_unit
//   Per-port input stage of a mesh router. Incoming flits are buffered in a
//   FIFO. The head flit's destination is presented to routing computation.
//   The returned output port is latched and requested from the switch
//   allocator. The packet is then forwarded wormhole-style up to its tail
//   flit. One credit is returned upstream for every flit popped.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   en           FSM / pop enable (also fed to the routing stage)
//   in_valid     upstream flit valid
//   in_flit      upstream flit
//   in_ready     FIFO has space (registered)
//   rc_dst       destination of the current head flit, to routing stage
//   rc_port      output port returned by the routing stage
//   req          switch-allocation request
//   req_port     requested output port (latched rc_port)
//   grant        allocator grant; out_flit consumed when out_valid=1
//   out_valid    flit available for the crossbar
//   out_flit     FIFO head flit
//   credit_out   one-cycle pulse per popped flit
//   err_drop     one-cycle pulse per discarded orphan non-head flit
//
// Flit format: [FLIT_W-1:FLIT_W-2] type (00 body, 01 head, 10 tail,
// 11 head+tail); head destination in [FLIT_W-3:FLIT_W-5].

module router_input_unit #(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [2:0]        rc_dst,
  input  logic [2:0]        rc_port,
  output logic              req,
  output logic [2:0]        req_port,
  input  logic              grant,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic              credit_out,
  output logic              err_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RC   = 2'd1,
    S_XFER = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_in_ready;

  // Control state
  state_t            r_state;
  logic [1:0]        r_rc_cnt;
  logic [2:0]        r_rc_dst;
  logic [2:0]        r_req_port;
  logic              r_req;
  logic              r_credit;
  logic              r_err_drop;

  logic [FLIT_W-1:0] w_head;
  logic              w_empty;
  logic              w_head_is_head;
  logic              w_head_is_tail;
  logic              w_push;
  logic              w_xfer_pop;
  logic              w_drop_pop;
  logic              w_pop;
  logic [CW-1:0]     w_count_nxt;

  assign w_head         = r_mem[r_rptr];
  assign w_empty        = (r_count == '0);
  // Type bit FLIT_W-2 marks a head (01/11), bit FLIT_W-1 marks a tail (10/11).
  assign w_head_is_head = w_head[FLIT_W-2];
  assign w_head_is_tail = w_head[FLIT_W-1];

  assign w_push     = in_valid && r_in_ready;
  assign w_xfer_pop = en && (r_state == S_XFER) && grant && !w_empty;
  assign w_drop_pop = en && (r_state == S_IDLE) && !w_empty && !w_head_is_head;
  assign w_pop      = w_xfer_pop || w_drop_pop;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Storage has no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_flit;
    end
  end

  // in_ready comes from the next-state count, so a pop never frees space
  // for a push in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rc_cnt   <= '0;
      r_rc_dst   <= '0;
      r_req_port <= '0;
      r_req      <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty && w_head_is_head) begin
            r_rc_dst <= w_head[FLIT_W-3:FLIT_W-5];
            r_rc_cnt <= '0;
            r_state  <= S_RC;
          end
        end
        S_RC: begin
          if (r_rc_cnt == 2'(RC_LAT)) begin
            r_req_port <= rc_port;
            r_req      <= 1'b1;
            r_state    <= S_XFER;
          end else begin
            r_rc_cnt <= r_rc_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (w_xfer_pop && w_head_is_tail) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit   <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_credit   <= w_pop;
      r_err_drop <= w_drop_pop;
    end
  end

  assign in_ready   = r_in_ready;
  assign rc_dst     = r_rc_dst;
  assign req        = r_req;
  assign req_port   = r_req_port;
  assign out_valid  = (r_state == S_XFER) && !w_empty;
  assign out_flit   = w_head;
  assign credit_out = r_credit;
  assign err_drop   = r_err_drop;

endmodule

// File: tb/tb_router_input_unit.sv
module tb_router_input_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [15:0] in_flit;
  logic        in_ready;
  logic [2:0]  rc_dst;
  logic [2:0]  rc_port;
  logic        req;
  logic [2:0]  req_port;
  logic        grant;
  logic        out_valid;
  logic [15:0] out_flit;
  logic        credit_out;
  logic        err_drop;

  int n_checks = 0;
  int n_errors = 0;

  router_input_unit #(.FLIT_W(16), .DEPTH(4), .RC_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_flit    (in_flit),
    .in_ready   (in_ready),
    .rc_dst     (rc_dst),
    .rc_port    (rc_port),
    .req        (req),
    .req_port   (req_port),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .credit_out (credit_out),
    .err_drop   (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        iv;
    logic [15:0] flit;
    logic [2:0]  rcp;
    logic        gnt;
    logic        rdy;
    logic        req;
    logic [2:0]  rport;
    logic [2:0]  rdst;
    logic        ov;
    logic [15:0] oflit;
    logic        cr;
    logic        drop;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic iv, logic [15:0] flit, logic [2:0] rcp, logic gnt,
                              logic rdy, logic rq, logic [2:0] rport, logic [2:0] rdst,
                              logic ov, logic [15:0] oflit, logic cr, logic drop);
    vec_t v;
    v.iv = iv; v.flit = flit; v.rcp = rcp; v.gnt = gnt;
    v.rdy = rdy; v.req = rq; v.rport = rport; v.rdst = rdst;
    v.ov = ov; v.oflit = oflit; v.cr = cr; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk(name, 32'(req), 32'd1);
  endtask

  logic [15:0] bp   [5];
  logic [15:0] enq  [3];

  initial begin
    // Single head+tail, 4-flit packet, then orphan body followed by a head.
    tbl[0]  = mk(1, 16'hE8A5, 3'b010, 0,  1, 0, 3'd0, 3'd0, 0, 16'h0, 0, 0);
    tbl[1]  = mk(0, 16'h0000, 3'b010, 0,  1, 0, 3'd0, 3'd5, 0, 16'h0, 0, 0);
    tbl[2]  = mk(0, 16'h0000, 3'b010, 0,  1, 0, 3'd0, 3'd5, 0, 16'h0, 0, 0);
    tbl[3]  = mk(0, 16'h0000, 3'b010, 0,  1, 1, 3'd2, 3'd5, 1, 16'hE8A5, 0, 0);
    tbl[4]  = mk(0, 16'h0000, 3'b010, 1,  1, 0, 3'd2, 3'd5, 0, 16'h0, 1, 0);
    tbl[5]  = mk(0, 16'h0000, 3'b010, 0,  1, 0, 3'd2, 3'd5, 0, 16'h0, 0, 0);
    tbl[6]  = mk(1, 16'h5801, 3'b100, 1,  1, 0, 3'd2, 3'd5, 0, 16'h0, 0, 0);
    tbl[7]  = mk(1, 16'h0002, 3'b100, 1,  1, 0, 3'd2, 3'd3, 0, 16'h0, 0, 0);
    tbl[8]  = mk(1, 16'h0003, 3'b100, 1,  1, 0, 3'd2, 3'd3, 0, 16'h0, 0, 0);
    tbl[9]  = mk(1, 16'h8004, 3'b100, 1,  0, 1, 3'd4, 3'd3, 1, 16'h5801, 0, 0);
    tbl[10] = mk(0, 16'h0000, 3'b100, 1,  1, 1, 3'd4, 3'd3, 1, 16'h0002, 1, 0);
    tbl[11] = mk(0, 16'h0000, 3'b100, 1,  1, 1, 3'd4, 3'd3, 1, 16'h0003, 1, 0);
    tbl[12] = mk(0, 16'h0000, 3'b100, 1,  1, 1, 3'd4, 3'd3, 1, 16'h8004, 1, 0);
    tbl[13] = mk(0, 16'h0000, 3'b100, 1,  1, 0, 3'd4, 3'd3, 0, 16'h0, 1, 0);
    tbl[14] = mk(0, 16'h0000, 3'b100, 0,  1, 0, 3'd4, 3'd3, 0, 16'h0, 0, 0);
    tbl[15] = mk(1, 16'h0123, 3'b001, 0,  1, 0, 3'd4, 3'd3, 0, 16'h0, 0, 0);
    tbl[16] = mk(1, 16'h4055, 3'b001, 0,  1, 0, 3'd4, 3'd3, 0, 16'h0, 1, 1);
    tbl[17] = mk(0, 16'h0000, 3'b001, 0,  1, 0, 3'd4, 3'd0, 0, 16'h0, 0, 0);
    tbl[18] = mk(0, 16'h0000, 3'b001, 0,  1, 0, 3'd4, 3'd0, 0, 16'h0, 0, 0);
    tbl[19] = mk(0, 16'h0000, 3'b001, 0,  1, 1, 3'd1, 3'd0, 1, 16'h4055, 0, 0);
    tbl[20] = mk(1, 16'h8077, 3'b001, 1,  1, 1, 3'd1, 3'd0, 1, 16'h8077, 1, 0);
    tbl[21] = mk(0, 16'h0000, 3'b001, 1,  1, 0, 3'd1, 3'd0, 0, 16'h0, 1, 0);
    tbl[22] = mk(0, 16'h0000, 3'b001, 0,  1, 0, 3'd1, 3'd0, 0, 16'h0, 0, 0);

    bp[0] = 16'h5010; bp[1] = 16'h0011; bp[2] = 16'h0012; bp[3] = 16'h0013; bp[4] = 16'h8014;
    enq[0] = 16'h0021; enq[1] = 16'h0022; enq[2] = 16'h8023;

    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0; in_flit = '0; rc_port = '0; grant = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_in_ready",  32'(in_ready),   32'd1);
    chk("reset_req",       32'(req),        32'd0);
    chk("reset_out_valid", 32'(out_valid),  32'd0);
    chk("reset_credit",    32'(credit_out), 32'd0);
    chk("reset_err_drop",  32'(err_drop),   32'd0);
    chk("reset_rc_dst",    32'(rc_dst),     32'd0);
    chk("reset_req_port",  32'(req_port),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      in_valid = tbl[i].iv;
      in_flit  = tbl[i].flit;
      rc_port  = tbl[i].rcp;
      grant    = tbl[i].gnt;
      tick;
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),   32'(tbl[i].rdy));
      chk($sformatf("v%0d_req", i),       32'(req),        32'(tbl[i].req));
      chk($sformatf("v%0d_req_port", i),  32'(req_port),   32'(tbl[i].rport));
      chk($sformatf("v%0d_rc_dst", i),    32'(rc_dst),     32'(tbl[i].rdst));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid),  32'(tbl[i].ov));
      if (tbl[i].ov)
        chk($sformatf("v%0d_out_flit", i), 32'(out_flit),  32'(tbl[i].oflit));
      chk($sformatf("v%0d_credit", i),    32'(credit_out), 32'(tbl[i].cr));
      chk($sformatf("v%0d_err_drop", i),  32'(err_drop),   32'(tbl[i].drop));
    end
    in_valid = 1'b0; grant = 1'b0;

    // Backpressure: five flits into a four-deep FIFO with no grant.
    rc_port = 3'b011;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_flit = bp[i];
      tick;
    end
    chk("bp_full_not_ready", 32'(in_ready), 32'd0);
    chk("bp_req_up",         32'(req),      32'd1);
    chk("bp_req_port",       32'(req_port), 32'd3);
    in_flit = bp[4];
    tick;
    chk("bp_fifth_held", 32'(in_ready), 32'd0);
    grant = 1'b1;
    tick;
    grant = 1'b0;
    chk("bp_ready_after_pop", 32'(in_ready),   32'd1);
    chk("bp_credit_pop",      32'(credit_out), 32'd1);
    chk("bp_next_head",       32'(out_flit),   32'h0011);
    tick;
    in_valid = 1'b0;
    chk("bp_fifth_accepted", 32'(in_ready), 32'd0);
    grant = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("bp_ov_%0d", k),   32'(out_valid), 32'd1);
      chk($sformatf("bp_flit_%0d", k), 32'(out_flit),  32'(bp[k]));
      tick;
      chk($sformatf("bp_credit_%0d", k), 32'(credit_out), 32'd1);
    end
    grant = 1'b0;
    chk("bp_req_dropped", 32'(req),       32'd0);
    chk("bp_empty",       32'(out_valid), 32'd0);
    chk("bp_ready_end",   32'(in_ready),  32'd1);

    // en=0 mid-transfer with grant held: no pops, writes still accepted.
    rc_port = 3'b110;
    in_valid = 1'b1; in_flit = 16'h7020; tick;
    in_flit = 16'h0021; tick;
    in_valid = 1'b0;
    wait_req("en_req_up");
    chk("en_req_port", 32'(req_port), 32'd6);
    chk("en_first",    32'(out_flit), 32'h7020);
    grant = 1'b1;
    tick;
    chk("en_credit_first", 32'(credit_out), 32'd1);
    en = 1'b0;
    in_valid = 1'b1; in_flit = 16'h0022; tick;
    chk("en_off_no_credit", 32'(credit_out), 32'd0);
    chk("en_off_head_held", 32'(out_flit),   32'h0021);
    chk("en_off_req_held",  32'(req),        32'd1);
    in_flit = 16'h8023; tick;
    chk("en_off_head_held2", 32'(out_flit),   32'h0021);
    chk("en_off_no_credit2", 32'(credit_out), 32'd0);
    in_valid = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("en_ov_%0d", k),   32'(out_valid), 32'd1);
      chk($sformatf("en_flit_%0d", k), 32'(out_flit),  32'(enq[k]));
      tick;
      chk($sformatf("en_credit_%0d", k), 32'(credit_out), 32'd1);
    end
    grant = 1'b0;
    chk("en_req_dropped", 32'(req), 32'd0);

    // Reset in the middle of a packet.
    rc_port = 3'b101;
    in_valid = 1'b1; in_flit = 16'h6030; tick;
    in_flit = 16'h0031; tick;
    in_valid = 1'b0;
    wait_req("rst_req_up");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req",       32'(req),        32'd0);
    chk("rst_mid_out_valid", 32'(out_valid),  32'd0);
    chk("rst_mid_in_ready",  32'(in_ready),   32'd1);
    chk("rst_mid_rc_dst",    32'(rc_dst),     32'd0);
    chk("rst_mid_req_port",  32'(req_port),   32'd0);
    chk("rst_mid_credit",    32'(credit_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick;
    chk("rst_after_req",    32'(req),       32'd0);
    chk("rst_after_rc_dst", 32'(rc_dst),    32'd0);
    chk("rst_after_ready",  32'(in_ready),  32'd1);
    chk("rst_after_credit", 32'(credit_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
